// File: rtl/systolic_mm_n.sv
// rtl/systolic_mm_n.sv - N x N output-stationary systolic matrix multiply (C = A x B or C += A x B)
module systolic_mm_n #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_data,
  input  logic                  acc_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*ACC_W-1:0]    out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(3 * N);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t            state;
  logic [CW-1:0]     beat_cnt;
  logic [CW-1:0]     cyc;
  logic [CW-1:0]     row_cnt;

  // a_mem/b_mem hold the loaded operands and double as the skew feeders:
  // each row/column shifts toward element 0 once its start cycle is reached.
  logic [DATA_W-1:0] a_mem [N][N];
  logic [DATA_W-1:0] b_mem [N][N];
  logic [DATA_W-1:0] a_r   [N][N-1];
  logic [DATA_W-1:0] b_r   [N-1][N];
  logic              v_r   [N][N-1];
  logic [ACC_W-1:0]  acc   [N][N];

  logic [DATA_W-1:0] beat  [N];
  logic              feed_v [N];
  logic [DATA_W-1:0] a_op  [N][N];
  logic [DATA_W-1:0] b_op  [N][N];
  logic              v_op  [N][N];
  logic [ACC_W-1:0]  term  [N][N];

  function automatic logic [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] xa;
    logic [2*DATA_W-1:0] xb;
    logic [2*DATA_W-1:0] p;
    logic                sx;
    xa = {{DATA_W{a[DATA_W-1] & SIGNED}}, a};
    xb = {{DATA_W{b[DATA_W-1] & SIGNED}}, b};
    p  = xa * xb;
    sx = p[2*DATA_W-1] & SIGNED;
    return {{(ACC_W-2*DATA_W){sx}}, p};
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      feed_v[i] = (state == COMPUTE) && (cyc >= CW'(i)) && (cyc < CW'(i + N));
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      assign beat[gi] = in_data[gi*DATA_W +: DATA_W];
      for (gj = 0; gj < N; gj++) begin : g_col
        if (gj == 0) begin : g_west
          assign a_op[gi][gj] = a_mem[gi][0];
          assign v_op[gi][gj] = feed_v[gi];
        end else begin : g_inner_a
          assign a_op[gi][gj] = a_r[gi][gj-1];
          assign v_op[gi][gj] = v_r[gi][gj-1];
        end
        if (gi == 0) begin : g_north
          assign b_op[gi][gj] = b_mem[gj][0];
        end else begin : g_inner_b
          assign b_op[gi][gj] = b_r[gi-1][gj];
        end
        assign term[gi][gj] = mac_term(a_op[gi][gj], b_op[gi][gj]);
      end
    end
  endgenerate

  always_comb begin
    out_data = '0;
    for (int r = 0; r < N; r++) begin
      if (row_cnt == CW'(r)) begin
        for (int j = 0; j < N; j++) out_data[j*ACC_W +: ACC_W] = acc[r][j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      cyc       <= '0;
      row_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
          acc[i][j]   <= '0;
        end
        for (int j = 0; j < N-1; j++) begin
          a_r[i][j] <= '0;
          v_r[i][j] <= 1'b0;
          b_r[j][i] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      // Stale valid bits from a previous job must never reach a PE.
      if (state != COMPUTE) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N-1; j++) v_r[i][j] <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int e = 0; e < N; e++) a_mem[0][e] <= beat[e];
            if (!acc_mode) begin
              for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) acc[i][j] <= '0;
            end
            beat_cnt <= CW'(1);
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            for (int r = 0; r < N; r++) begin
              for (int e = 0; e < N; e++) begin
                if (beat_cnt == CW'(r))     a_mem[r][e] <= beat[e];
                if (beat_cnt == CW'(N + r)) b_mem[r][e] <= beat[e];
              end
            end
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CW'(2*N - 1)) begin
              state    <= COMPUTE;
              cyc      <= '0;
              in_ready <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          for (int i = 0; i < N; i++) begin
            if (cyc >= CW'(i)) begin
              for (int e = 0; e < N-1; e++) begin
                a_mem[i][e] <= a_mem[i][e+1];
                b_mem[i][e] <= b_mem[i][e+1];
              end
              a_mem[i][N-1] <= '0;
              b_mem[i][N-1] <= '0;
            end
          end
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              if (j < N-1) begin
                a_r[i][j] <= a_op[i][j];
                v_r[i][j] <= v_op[i][j];
              end
              if (i < N-1) b_r[i][j] <= b_op[i][j];
              if (v_op[i][j]) acc[i][j] <= acc[i][j] + term[i][j];
            end
          end
          if (cyc == CW'(3*N - 3)) begin
            state     <= DRAIN;
            row_cnt   <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (row_cnt == CW'(N - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              done      <= 1'b1;
            end else begin
              row_cnt  <= row_cnt + 1'b1;
              out_last <= (row_cnt == CW'(N - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/systolic_mm_n.md
Name: systolic_mm_n

Overview:
Parametrised successor to the 4x4 matrix-multiply top: an N x N output-stationary systolic array that computes C = A x B, or C += A x B in accumulate mode.
- Operands stream in one row or column per beat over a valid/ready input channel.
- Internal skew feeders drive an N x N grid of MAC PEs.
- Results drain one C row per beat over a valid/ready output channel.
- Sits between the operand DMA/input buffer and the result writeback path.

Parameters:
N, 4, array dimension (N x N PEs), legal range 2..16
DATA_W, 8, operand element width
ACC_W, 32, accumulator/result element width, must be >= 2*DATA_W + clog2(N)
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned operands

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  operand beat ready
in_data  input  N*DATA_W  operand beat; element e at [e*DATA_W +: DATA_W]
acc_mode  input  1  sampled with first beat of a job; 1 = accumulate onto existing C
out_valid  output  1  result row valid
out_ready  input  1  result row ready
out_data  output  N*ACC_W  result row; C[r][j] at [j*ACC_W +: ACC_W]
out_last  output  1  high with row N-1
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse, job complete

Behaviour:
- Reset (reset low, async) forces:
  - state IDLE; all counters 0; all accumulators 0; feeder regs 0.
  - in_ready=1, out_valid=0, out_last=0, done=0, busy=0, out_data=0.
- Reset mid-job aborts the job; no partial output follows.
- Handshake rules:
  - A beat transfers on valid && ready at a clk edge.
  - in_ready=1 only in IDLE and LOAD.
  - out_data/out_last hold stable while out_valid && !out_ready.
- FSM states IDLE -> LOAD -> COMPUTE -> DRAIN -> IDLE.
- IDLE:
  - The first accepted beat is A row 0. It latches acc_mode and moves to LOAD with beat_cnt=1.
  - If acc_mode=0, all accumulators clear on that edge. If acc_mode=1, accumulators are retained.
- LOAD:
  - Beats 0..N-1 are A rows 0..N-1; beats N..2N-1 are B columns 0..N-1.
  - in_valid gaps stall loading with no side effects.
  - The edge accepting beat 2N-1 enters COMPUTE with cyc=0.
- COMPUTE:
  - Runs exactly 3N-2 cycles, cyc = 0..3N-3; in_ready=0.
  - At cycle t, PE(i,j) performs acc += A[i][k]*B[k][j], where k = t-i-j, only when 0 <= k < N. Otherwise the PE holds.
  - Skew is realised by feeder shift registers: row i delayed i cycles, column j delayed j cycles.
  - Products are sign- or zero-extended to ACC_W per SIGNED. The sum wraps modulo 2^ACC_W; no saturation.
  - After cyc=3N-3, enter DRAIN with row=0.
- DRAIN:
  - out_valid=1 and out_data = C[row]; out_last = (row==N-1).
  - On transfer, row increments. Transfer of row N-1 returns to IDLE with done=1 for exactly that next cycle.
  - out_ready low stalls indefinitely with no data change.
- Latency: first out_valid asserts 3N-2 cycles after the edge accepting the final B beat (N=4: 10 cycles).
- Accumulators persist after DRAIN, so a following acc_mode=1 job adds onto them (K-tiling).
- Simultaneous events: in_valid during COMPUTE/DRAIN is ignored. A new job's first beat may be accepted in the same cycle done is high (IDLE).
- acc_mode changes mid-job have no effect.

Test Plan:
- N=4, SIGNED=1, acc_mode=0: A=identity, B[k][j]=4k+j. Required: out rows equal B^T rows? No: C=B, so row r = {4r+3,4r+2,4r+1,4r} packed high to low. First out_valid 10 cycles after last input beat; out_last on row 3; done one cycle after row 3 transfers.
- Signed extremes: all A and B elements = -128, N=4. Required: every C element = 65536. With SIGNED=0 and all elements 255: every C element = 260100.
- Accumulate: run job 1 with A=B=all-ones (C=4 everywhere), then job 2 with the same data and acc_mode=1. Required: all C elements = 8. Job 3 with acc_mode=0 yields 4.
- Backpressure and gaps: in_valid toggles 1/0 during LOAD; out_ready is held low 5 cycles on row 1. Required: identical results to the unstalled run, and out_data stable throughout the stall.
- Reset mid-COMPUTE (cyc=5), then release and run a fresh job. Required: out_valid stays 0 through reset; the next job's results are correct, with no residual accumulation.
- Parameter sweep N=2, DATA_W=4: A={{1,2},{3,4}}, B={{5,6},{7,8}}. Required: C rows {19,22} and {43,50}; first out_valid 4 cycles after last input beat.
